// File: rtl/keypad_pkg.sv
// Shared keypad types: debouncer state encoding and the 4-bit key code used by
// the scanner, the debouncer and the display driver.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  typedef logic [3:0] key_code_t;

endpackage

// File: rtl/keypad_debounce_sync2.sv
// Two-flop synchroniser for the asynchronous key-down flag; 2-cycle latency,
// synchronous active-low reset clears both stages to 0.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/keypad_debounce.sv
// Keypad debouncer: one key_valid pulse per qualified press, 2+DEBOUNCE_CYCLES+1 edges after a
// stable rise; freezes the scanner while qualifying/holding. KEY_REPEAT_EN adds auto-repeat.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  input  logic [3:0] key_code,
  output logic       scan_hold,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic ksync;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (key_raw),
    .q     (ksync)
  );

  deb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  key_code_t cap_code_q, cap_code_d;
  logic key_valid_q, key_valid_d;
  key_code_t key_value_q, key_value_d;
  key_code_t digit_new_q, digit_new_d;
  key_code_t digit_old_q, digit_old_d;
  logic fire;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt_q, rcnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_code_d  = cap_code_q;
    key_valid_d = 1'b0;
    key_value_d = key_value_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    fire        = 1'b0;
`ifdef KEY_REPEAT_EN
    rcnt_d      = rcnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (ksync) begin
          state_d    = PRESS_WAIT;
          cap_code_d = key_code;
          cnt_d      = '0;
        end
      end
      PRESS_WAIT: begin
        if (!ksync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
`ifdef KEY_REPEAT_EN
          rcnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!ksync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef KEY_REPEAT_EN
        // Repeat timing only advances while the key reads down in HELD.
        else if (rcnt_q == RCNT_LAST) begin
          fire   = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
`endif
      end
      RELEASE_WAIT: begin
        if (ksync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (fire) begin
      key_valid_d = 1'b1;
      key_value_d = cap_code_q;
      digit_old_d = digit_new_q;
      digit_new_d = cap_code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_value_q <= '0;
      digit_new_q <= '0;
      digit_old_q <= '0;
`ifdef KEY_REPEAT_EN
      rcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_code_q  <= cap_code_d;
      key_valid_q <= key_valid_d;
      key_value_q <= key_value_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
`ifdef KEY_REPEAT_EN
      rcnt_q      <= rcnt_d;
`endif
    end
  end

  assign scan_hold = (state_q != IDLE);
  assign key_valid = key_valid_q;
  assign key_value = key_value_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;

endmodule
